fifo_ctrl: RTL

//  Sequential control stage of the 8-entry FIFO: holds the operation-state register and the head/tail/count registers.

---
 rtl/fifo_ctrl_pkg.sv | 17 +
 rtl/fifo_ctrl_ns.sv | 27 ++
 rtl/fifo_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO control stage: default geometry and the
// operation-state encoding seen by the FIFO top and the pointer stage.
package fifo_ctrl_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH = 3;
    localparam int unsigned FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_NO_OP    = 3'b001,
        ST_WRITE    = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_READ     = 3'b100,
        ST_RD_ERROR = 3'b101
    } state_t;

endpackage

// File: rtl/fifo_ctrl_ns.sv
// Next-state decode for the FIFO control stage; judged on the occupancy
// that will hold once the operation in flight this cycle has completed.
module fifo_ctrl_ns
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [ADDR_WIDTH:0] proj_count,
    output state_t              next_state
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    // Simultaneous or absent requests both collapse to NO_OP.
    always_comb begin
        next_state = ST_NO_OP;
        if (wr_en && !rd_en) begin
            next_state = (proj_count < CW'(DEPTH)) ? ST_WRITE : ST_WR_ERROR;
        end else if (rd_en && !wr_en) begin
            next_state = (proj_count != '0) ? ST_READ : ST_RD_ERROR;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: operation-state, head/tail/count registers and the
// Moore decode of register-file strobes and client handshake flags.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [2:0]            state,
    output logic [ADDR_WIDTH-1:0] head,
    output logic [ADDR_WIDTH-1:0] tail,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  we,
    output logic                  re,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   proj_count;

    // Occupancy after the operation of the current cycle commits.
    always_comb begin
        proj_count = data_count;
        if (state_q == ST_WRITE) begin
            proj_count = data_count + CW'(1);
        end else if (state_q == ST_READ) begin
            proj_count = data_count - CW'(1);
        end
    end

    fifo_ctrl_ns #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ns (
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .proj_count (proj_count),
        .next_state (state_d)
    );

    // State, pointers and count; pointers wrap through the natural carry-out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            head       <= '0;
            tail       <= '0;
            data_count <= '0;
        end else begin
            state_q    <= state_d;
            data_count <= proj_count;
            if (state_q == ST_WRITE) begin
                tail <= tail + ADDR_WIDTH'(1);
            end
            if (state_q == ST_READ) begin
                head <= head + ADDR_WIDTH'(1);
            end
        end
    end

    assign state = state_q;
    assign full  = (data_count == CW'(DEPTH));
    assign empty = (data_count == '0);

    // Strobes and flags depend on the registered state only.
    always_comb begin
        we     = 1'b0;
        re     = 1'b0;
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
        case (state_q)
            ST_WRITE: begin
                we     = 1'b1;
                wr_ack = 1'b1;
            end
            ST_READ: begin
                re     = 1'b1;
                rd_ack = 1'b1;
            end
            ST_WR_ERROR: wr_err = 1'b1;
            ST_RD_ERROR: rd_err = 1'b1;
            default: ;
        endcase
    end

endmodule
